// File: rtl/lcd_responder_pkg.sv
// Shared constants, types and address helpers for the character-LCD bus responder.
// DDRAM is two 40-byte lines at 0x00 and 0x40, packed into one 80-entry array.
package lcd_pkg;

  localparam int T_CLEAR_DEF = 76000;
  localparam int T_CMD_DEF   = 1850;

  // Instruction opcodes, decoded by their highest set bit
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_LEN   = 7'd40;
  localparam logic [6:0] LINE1_END  = LINE1_BASE + LINE_LEN - 7'd1;
  localparam logic [6:0] LINE2_END  = LINE2_BASE + LINE_LEN - 7'd1;
  localparam logic [6:0] LAST_IDX   = 7'd79;
  localparam int         DDRAM_SIZE = 80;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_BUSY_WAIT = 2'd2
  } lcd_state_e;

  typedef struct packed {
    logic dl;
    logic n;
    logic id;
    logic s;
    logic d;
    logic c;
    logic b;
  } lcd_mode_t;

  localparam lcd_mode_t MODE_RESET = '{dl: 1'b1, n: 1'b0, id: 1'b1, s: 1'b0,
                                       d: 1'b0, c: 1'b0, b: 1'b0};

  function automatic logic addr_valid(input logic [6:0] a);
    logic ok;
    if (a <= LINE1_END) ok = 1'b1;
    else if ((a >= LINE2_BASE) && (a <= LINE2_END)) ok = 1'b1;
    else ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
    logic [6:0] idx;
    if (a <= LINE1_END) idx = a - LINE1_BASE;
    else if ((a >= LINE2_BASE) && (a <= LINE2_END)) idx = a - LINE2_BASE + LINE_LEN;
    else idx = 7'd0;
    return idx;
  endfunction

  // Address counter step; each line end wraps to the start of the other line
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (a == LINE1_END) n = LINE2_BASE;
      else if (a == LINE2_END) n = LINE1_BASE;
      else n = a + 7'd1;
    end else begin
      if (a == LINE1_BASE) n = LINE2_END;
      else if (a == LINE2_BASE) n = LINE1_END;
      else n = a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// Initiator-side LCD bus: strobe, register select, direction and both data directions.
interface lcd_bus_if;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA_IN;
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE;

  modport master (output LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN,
                  input  LCD_DATA_OUT, LCD_DATA_OE);
  modport slave  (input  LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN,
                  output LCD_DATA_OUT, LCD_DATA_OE);
endinterface

// File: rtl/lcd_responder_edge_sync.sv
// Two-flop synchronizer for the asynchronous bus, plus an EN falling-edge pulse.
// A third stage keeps RS/RW/DATA from the last EN-high cycle for the completing transfer.
module lcd_edge_sync (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] data_i,
  output logic       en_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic       fall_o,
  output logic       rs_last_o,
  output logic       rw_last_o,
  output logic [7:0] data_last_o
);
  logic [10:0] s1_q, s2_q, s3_q;

  // Synchronizer chain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 11'd0;
      s2_q <= 11'd0;
      s3_q <= 11'd0;
    end else begin
      s1_q <= {en_i, rs_i, rw_i, data_i};
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign en_o        = s2_q[10];
  assign rs_o        = s2_q[9];
  assign rw_o        = s2_q[8];
  assign fall_o      = s3_q[10] & ~s2_q[10];
  assign rs_last_o   = s3_q[9];
  assign rw_last_o   = s3_q[8];
  assign data_last_o = s3_q[7:0];
endmodule

// File: rtl/lcd_responder.sv
// HD44780-style LCD bus responder: DDRAM, address counter, busy timing, clear sweep,
// sticky error flags and an independent display read port.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int T_CLEAR = T_CLEAR_DEF,
  parameter int T_CMD   = T_CMD_DEF
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  lcd_bus_if.slave    bus,
  input  logic [6:0]  DISP_ADDR,
  output logic [7:0]  DISP_CHAR,
  output logic [7:0]  STATUS,
  output logic [6:0]  AC,
  output logic [1:0]  ERR
);
  localparam int CNT_W = $clog2(T_CLEAR + 1);

  lcd_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        idx_q, idx_d, ac_q, ac_d;
  lcd_mode_t         mode_q, mode_d;
  logic [1:0]        err_q, err_d;
  logic              busy_q, oe_q, oe_d;
  logic [7:0]        dout_q, dout_d, disp_q, disp_d;
  logic [7:0]        ram_q [DDRAM_SIZE];
  logic              ram_we_s;
  logic [6:0]        ram_wa_s;
  logic [7:0]        ram_wd_s;
  logic              en_s, rs_s, rw_s, fall_s, rs_last_s, rw_last_s;
  logic [7:0]        data_last_s;

  lcd_edge_sync u_sync (
    .clk_i(CLOCK_50), .rst_i(RESET),
    .en_i(bus.LCD_EN), .rs_i(bus.LCD_RS), .rw_i(bus.LCD_RW), .data_i(bus.LCD_DATA_IN),
    .en_o(en_s), .rs_o(rs_s), .rw_o(rw_s), .fall_o(fall_s),
    .rs_last_o(rs_last_s), .rw_last_o(rw_last_s), .data_last_o(data_last_s)
  );

  // Transaction decode, then FSM; the sweep end overrides any AC step from a read
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ac_d     = ac_q;
    mode_d   = mode_q;
    err_d    = err_q;
    ram_we_s = 1'b0;
    ram_wa_s = addr_to_idx(ac_q);
    ram_wd_s = data_last_s;
    if (fall_s) begin
      case ({rs_last_s, rw_last_s})
        2'b11: begin
          ac_d     = ac_step(ac_q, mode_q.id);
          err_d[0] = err_q[0] | busy_q;
        end
        2'b10: begin
          if (busy_q) begin
            err_d[0] = 1'b1;
          end else begin
            ram_we_s = 1'b1;
            ac_d     = ac_step(ac_q, mode_q.id);
            state_d  = ST_BUSY_WAIT;
            cnt_d    = CNT_W'(T_CMD);
          end
        end
        2'b00: begin
          if (busy_q) begin
            err_d[0] = 1'b1;
          end else begin
            state_d = ST_BUSY_WAIT;
            cnt_d   = CNT_W'(T_CMD);
            if (|(data_last_s & OP_SET_DDRAM)) begin
              if (addr_valid(data_last_s[6:0])) ac_d = data_last_s[6:0];
              else err_d[1] = 1'b1;
            end else if (|(data_last_s & OP_SET_CGRAM)) begin
              err_d[1] = 1'b1;
            end else if (|(data_last_s & OP_FUNC_SET)) begin
              mode_d.dl = data_last_s[4];
              mode_d.n  = data_last_s[3];
            end else if (|(data_last_s & OP_SHIFT)) begin
              if (!data_last_s[3]) ac_d = ac_step(ac_q, data_last_s[2]);
              else ac_d = ac_q;
            end else if (|(data_last_s & OP_DISP_CTRL)) begin
              mode_d.d = data_last_s[2];
              mode_d.c = data_last_s[1];
              mode_d.b = data_last_s[0];
            end else if (|(data_last_s & OP_ENTRY)) begin
              mode_d.id = data_last_s[1];
              mode_d.s  = data_last_s[0];
            end else if (|(data_last_s & OP_HOME)) begin
              ac_d = LINE1_BASE;
            end else if (|(data_last_s & OP_CLEAR)) begin
              state_d = ST_CLEAR;
              idx_d   = 7'd0;
              cnt_d   = CNT_W'(T_CLEAR);
            end else begin
              state_d = ST_IDLE;
              cnt_d   = cnt_q;
            end
          end
        end
        default: ;
      endcase
    end else begin
      ram_we_s = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
      end
      ST_CLEAR: begin
        ram_we_s = 1'b1;
        ram_wa_s = idx_q;
        ram_wd_s = SPACE_CHAR;
        cnt_d    = cnt_q - CNT_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d   = ST_BUSY_WAIT;
          ac_d      = LINE1_BASE;
          mode_d.id = 1'b1;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      ST_BUSY_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        else state_d = ST_BUSY_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-back and display-port next values
  always_comb begin
    oe_d = en_s & rw_s;
    if (!oe_d) dout_d = 8'h00;
    else if (rs_s) dout_d = ram_q[addr_to_idx(ac_q)];
    else dout_d = {busy_q, ac_q};
    if (addr_valid(DISP_ADDR)) disp_d = ram_q[addr_to_idx(DISP_ADDR)];
    else disp_d = SPACE_CHAR;
  end

  // Control and output registers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CNT_W'(T_CLEAR);
      idx_q   <= 7'd0;
      ac_q    <= LINE1_BASE;
      mode_q  <= MODE_RESET;
      err_q   <= 2'b00;
      busy_q  <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      disp_q  <= SPACE_CHAR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ac_q    <= ac_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      disp_q  <= disp_d;
    end
  end

  // DDRAM write port; suppressed under reset so an aborted sweep or transfer leaves no write
  always_ff @(posedge CLOCK_50) begin
    if (ram_we_s && !RESET) ram_q[ram_wa_s] <= ram_wd_s;
  end

  assign bus.LCD_DATA_OUT = dout_q;
  assign bus.LCD_DATA_OE  = oe_q;
  assign DISP_CHAR        = disp_q;
  assign STATUS           = {busy_q, mode_q};
  assign AC               = ac_q;
  assign ERR              = err_q;
endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 Parameter T_CLEAR, 76000, busy cycles after Clear Display (1.52 ms at 50 MHz).
REQ-002 Parameter T_CMD, 1850, busy cycles after any other accepted write (37 us at 50 MHz).
REQ-003 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 LCD_EN  in  1  bus enable from initiator; asynchronous to CLOCK_50.
REQ-006 LCD_RS  in  1  0 = instruction/status, 1 = data.
REQ-007 LCD_RW  in  1  0 = write, 1 = read.
REQ-008 LCD_DATA_IN  in  8  bus value driven by initiator.
REQ-009 LCD_DATA_OUT  out  8  read-back value.
REQ-010 LCD_DATA_OE  out  1  high while responder drives bus.
REQ-011 DISP_ADDR  in  7  display read-port DDRAM address.
REQ-012 DISP_CHAR  out  8  DDRAM content at DISP_ADDR, 1-cycle latency.
REQ-013 STATUS  out  8  {BUSY, DL, N, I/D, S, D, C, B}.
REQ-014 AC  out  7  current address counter.
REQ-015 ERR  out  2  sticky {ADDR_ERR, OVERRUN}.

Function
REQ-016 LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN shall pass a 2-flop synchronizer; a transaction completes on the synchronized EN falling edge, using RS/RW/DATA sampled in the last EN-high cycle.
REQ-017 LCD_DATA_OE shall be high exactly while synchronized EN=1 and RW=1; LCD_DATA_OUT = {BUSY, AC} when RS=0, DDRAM[AC] when RS=1, else 0x00.
REQ-018 DDRAM: 80 bytes, line 1 AC 0x00-0x27 -> index 0-39, line 2 AC 0x40-0x67 -> index 40-79.
REQ-019 AC step: I/D=1 increments, 0x27 -> 0x40, 0x67 -> 0x00; I/D=0 decrements, 0x00 -> 0x67, 0x40 -> 0x27.
REQ-020 Data write (RS=1,RW=0): DDRAM[AC] <= DATA, AC steps, BUSY for T_CMD.
REQ-021 Data read (RS=1,RW=1): AC steps on EN fall; no BUSY.
REQ-022 Status read (RS=0,RW=1): no state change; permitted while BUSY.
REQ-023 Instruction decode by highest set bit: 0x80 set DDRAM addr; 0x40 set CGRAM addr (ignored, ADDR_ERR set); 0x20 function set (store DL=D[4], N=D[3]); 0x10 shift (S/C=0: AC moves per R/L=D[2] using REQ-019 wrap; S/C=1: no-op); 0x08 display control (D,C,B = D[2:0]); 0x04 entry mode (I/D=D[1], S=D[0]); 0x02 return home (AC=0); 0x01 clear; 0x00 no-op without BUSY.
REQ-024 Set DDRAM address to 0x28-0x3F or 0x68-0x7F shall be ignored and set ADDR_ERR.
REQ-025 Clear: FSM IDLE -> CLEAR sweeps index 0..79 writing 0x20, one per cycle, then AC=0, I/D=1 -> BUSY_WAIT for remainder of T_CLEAR -> IDLE.
REQ-026 Write completing while BUSY=1 shall be discarded and set OVERRUN; data read while BUSY=1 returns DDRAM[AC], steps AC, sets OVERRUN.
REQ-027 Busy counter loads T_CLEAR or T_CMD on the cycle after EN fall; BUSY drops the cycle count reaches 0.
REQ-028 DISP_CHAR for invalid DISP_ADDR shall be 0x20; read port is independent of bus activity.
REQ-029 DL=0 stored but 4-bit transfers unsupported; bus handling stays 8-bit.

Reset
REQ-030 RESET shall force: AC=0, I/D=1, S=0, D=C=B=0, DL=1, N=0, ERR=0, OE=0, DATA_OUT=0x00, synchronizers cleared, FSM into CLEAR (BUSY=1, DDRAM filled with 0x20, then T_CLEAR wait).
REQ-031 RESET mid-transaction or mid-sweep shall abort it; no partial write completes afterward.

Structure
REQ-032 Package lcd_pkg holds opcode masks, DDRAM line bases/lengths (0x00/0x40, 40), space code 0x20, default T_CLEAR/T_CMD.
REQ-033 Sub-module lcd_edge_sync: 2-flop synchronizer plus EN falling-edge pulse.

Verification
REQ-034 Reset -> BUSY=1 for T_CLEAR cycles; DISP_CHAR=0x20 at DISP_ADDR 0x00, 0x27, 0x67.
REQ-035 Write 0x38,0x0C,0x06,0x80 then data 0x4C,0x45 (each after BUSY clears) -> DDRAM[0]=0x4C, [1]=0x45, AC=0x02, STATUS[3:0]=0b0100.
REQ-036 Set address 0xA7, write 0x41, 0x42 -> DDRAM[39]=0x41, DDRAM[40]=0x42, AC=0x41; entry 0x04, set 0xC0, write 0x43 -> AC=0x27.
REQ-037 Write 0x55 during BUSY -> DDRAM unchanged, ERR[0]=1; status read during BUSY -> OE=1, DATA_OUT[7]=1.
REQ-038 Set address 0xB0 -> AC unchanged, ERR[1]=1; clear 0x01 -> all 80 bytes 0x20, AC=0, BUSY for T_CLEAR.
REQ-039 Assert RESET during clear sweep at index 30 -> full sweep restarts, all bytes 0x20, ERR=0.
